// File: rtl/multicycle_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer for an RV32I datapath |
// | rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module multicycle_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        iord,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic        pc_src,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        retire,
  output logic [31:0] instret,
  output logic        fault,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_FAULT  = 3'd7
  } state_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  // Timeout fires on the not-ready cycle that would bring the count to TIMEOUT.
  localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT - 1);

  state_t      state_q;
  state_t      state_d;
  logic [7:0]  wait_cnt;
  logic [31:0] instret_q;
  logic        fault_q;

  logic [6:0]  opcode;
  logic        is_r;
  logic        is_i;
  logic        is_lw;
  logic        is_sw;
  logic        is_br;
  logic        is_jal;
  logic        legal;
  logic        mem_phase;
  logic        waiting;
  logic        timed_out;
  logic        unused_instr_hi;

  assign opcode          = instr[6:0];
  assign unused_instr_hi = ^instr[31:7];

  assign is_r   = (opcode == OP_R);
  assign is_i   = (opcode == OP_I);
  assign is_lw  = (opcode == OP_LW);
  assign is_sw  = (opcode == OP_SW);
  assign is_br  = (opcode == OP_BR);
  assign is_jal = (opcode == OP_JAL);
  assign legal  = is_r | is_i | is_lw | is_sw | is_br | is_jal;

  // Derived from state rather than mem_req so the timeout path has no comb loop.
  assign mem_phase = (state_q == S_FETCH) || (state_q == S_MEM);
  assign waiting   = mem_phase && !mem_ready;
  assign timed_out = waiting && (wait_cnt == WAIT_LIMIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      wait_cnt  <= 8'd0;
      instret_q <= 32'd0;
      fault_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_cnt <= waiting ? wait_cnt + 8'd1 : 8'd0;
      if (retire) begin
        instret_q <= instret_q + 32'd1;
      end
      if (state_d == S_FAULT) begin
        fault_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    retire        = 1'b0;

    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end

      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (timed_out) begin
          state_d = S_FAULT;
        end
      end

      S_DECODE: begin
        alu_src_b = 2'b10;
        state_d   = legal ? S_EXEC : S_FAULT;
      end

      S_EXEC: begin
        if (is_r) begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
          state_d   = S_WB;
        end else if (is_i) begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          alu_op    = 2'b10;
          state_d   = S_WB;
        end else if (is_lw || is_sw) begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          state_d   = S_MEM;
        end else if (is_br) begin
          alu_src_a     = 1'b1;
          alu_op        = 2'b01;
          pc_write_cond = 1'b1;
          pc_src        = 1'b1;
          retire        = 1'b1;
          state_d       = S_FETCH;
        end else if (is_jal) begin
          reg_write = 1'b1;
          pc_write  = 1'b1;
          pc_src    = 1'b1;
          retire    = 1'b1;
          state_d   = S_FETCH;
        end else begin
          state_d = S_FAULT;
        end
      end

      S_MEM: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = is_sw;
        if (mem_ready) begin
          if (is_sw) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (timed_out) begin
          state_d = S_FAULT;
        end
      end

      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = is_lw;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end

      S_FAULT: begin
        state_d = S_FAULT;
      end

      default: begin
        state_d = S_FAULT;
      end
    endcase
  end

  assign instret = instret_q;
  assign fault   = fault_q;
  assign state   = state_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// Bench for multicycle_ctrl: directed vector table, timeout sequences, randomized run vs model.
module tb_multicycle_ctrl;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        mem_ready;
  logic        mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, pc_src, alu_src_a;
  logic [1:0]  alu_src_b, alu_op;
  logic        reg_write, mem_to_reg, retire, fault;
  logic [31:0] instret;
  logic [2:0]  state;

  multicycle_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .instr(instr), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .retire(retire),
    .instret(instret), .fault(fault), .state(state)
  );

  always #5 clk = ~clk;

  wire [15:0] ctl = {mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, pc_src,
                     alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg, retire, fault};

  localparam logic [31:0] ADD = 32'h002081B3, LW = 32'h0000A103, SW = 32'h00112023;
  localparam logic [31:0] BEQ = 32'h00208463, JAL = 32'h0080006F, BAD = 32'h0000007F;

  typedef struct {
    bit          rst;
    bit          rdy;
    logic [31:0] ins;
    logic [2:0]  st;
    logic [15:0] ctl;
    logic [31:0] cnt;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  int          m_st, m_wait, m_cls;
  logic [31:0] m_instret;
  int          m_route[$];

  task automatic add(input bit r, input bit rd, input logic [31:0] ins,
                     input logic [2:0] st, input logic [15:0] c, input logic [31:0] n);
    vec_t v;
    v.rst = r; v.rdy = rd; v.ins = ins; v.st = st; v.ctl = c; v.cnt = n;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input bit r, input bit rd, input logic [31:0] ins);
    reset = r; mem_ready = rd; instr = ins;
    #3;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  function automatic int cls_of(input logic [6:0] op);
    case (op)
      7'h33:   return 0;
      7'h13:   return 1;
      7'h03:   return 2;
      7'h23:   return 3;
      7'h63:   return 4;
      7'h6F:   return 5;
      default: return 6;
    endcase
  endfunction

  // Expected control word for a phase of an instruction; last = no steps remain after this one.
  function automatic logic [15:0] exp_ctl(input int st, input int cls, input bit rdy, input bit last);
    logic req, we, io, irw, pcw, pwc, psrc, a, rw, m2r, ret, flt;
    logic [1:0] b, op;
    {req, we, io, irw, pcw, pwc, psrc, a, rw, m2r, ret, flt} = '0;
    b = 2'b00; op = 2'b00;
    case (st)
      1: begin req = 1; b = 2'b01; irw = rdy; pcw = rdy; end
      2: b = 2'b10;
      3: begin
        case (cls)
          0: begin a = 1; op = 2'b10; end
          1: begin a = 1; b = 2'b10; op = 2'b10; end
          2, 3: begin a = 1; b = 2'b10; end
          4: begin a = 1; op = 2'b01; pwc = 1; psrc = 1; end
          5: begin rw = 1; pcw = 1; psrc = 1; end
          default: ;
        endcase
        ret = last;
      end
      4: begin req = 1; io = 1; we = (cls == 3); ret = last && rdy; end
      5: begin rw = 1; m2r = (cls == 2); ret = last; end
      7: flt = 1;
      default: ;
    endcase
    return {req, we, io, irw, pcw, pwc, psrc, a, b, op, rw, m2r, ret, flt};
  endfunction

  task automatic model_step(input bit r, input bit rd, input logic [31:0] ins);
    int old;
    old = m_st;
    if (r) begin
      m_st = 0; m_wait = 0; m_instret = 0; m_route.delete();
    end else begin
      case (m_st)
        0: m_st = 1;
        1, 4: begin
          if (rd) begin
            if (m_st == 1) m_st = 2;
            else if (m_route.size() == 0) begin m_instret++; m_st = 1; end
            else m_st = m_route.pop_front();
          end else begin
            m_wait++;
            if (m_wait >= TO) m_st = 7;
          end
        end
        2: begin
          m_cls = cls_of(ins[6:0]);
          m_route.delete();
          case (m_cls)
            0, 1: begin m_route.push_back(3); m_route.push_back(5); end
            2: begin m_route.push_back(3); m_route.push_back(4); m_route.push_back(5); end
            3: begin m_route.push_back(3); m_route.push_back(4); end
            4, 5: m_route.push_back(3);
            default: ;
          endcase
          m_st = (m_cls == 6) ? 7 : m_route.pop_front();
        end
        3, 5: begin
          if (m_route.size() == 0) begin m_instret++; m_st = 1; end
          else m_st = m_route.pop_front();
        end
        default: ;
      endcase
    end
    if (m_st != old) m_wait = 0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops[6] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F};
    logic [6:0] ill[4] = '{7'h7F, 7'h37, 7'h17, 7'h00};
    logic [31:0] hi;
    hi = $urandom;
    if ($urandom_range(0, 19) == 0) return {hi[31:7], ill[$urandom_range(0, 3)]};
    return {hi[31:7], ops[$urandom_range(0, 5)]};
  endfunction

  initial begin
    int pct;
    bit r, rd;
    logic [31:0] cur;

    reset = 1'b1; mem_ready = 1'b0; instr = ADD;
    adv();

    add(1,0,ADD,0,16'h0000,0); add(1,0,ADD,0,16'h0000,0); add(0,1,ADD,0,16'h0000,0);
    add(0,1,ADD,1,16'h9840,0); add(0,1,ADD,2,16'h0080,0); add(0,1,ADD,3,16'h0120,0);
    add(0,1,ADD,5,16'h000A,0);
    add(0,1,LW,1,16'h9840,1);  add(0,1,LW,2,16'h0080,1);  add(0,1,LW,3,16'h0180,1);
    for (int i = 0; i < 4; i++) add(0,0,LW,4,16'hA000,1);
    add(0,1,LW,4,16'hA000,1);  add(0,1,LW,5,16'h000E,1);
    add(0,1,SW,1,16'h9840,2);  add(0,1,SW,2,16'h0080,2);  add(0,1,SW,3,16'h0180,2);
    add(0,1,SW,4,16'hE002,2);
    add(0,1,BEQ,1,16'h9840,3); add(0,1,BEQ,2,16'h0080,3); add(0,1,BEQ,3,16'h0712,3);
    add(0,0,JAL,1,16'h8040,4); add(0,1,JAL,1,16'h9840,4); add(0,1,JAL,2,16'h0080,4);
    add(0,1,JAL,3,16'h0A0A,4);
    add(0,1,BAD,1,16'h9840,5); add(0,1,BAD,2,16'h0080,5); add(0,1,BAD,7,16'h0001,5);
    add(0,0,BAD,7,16'h0001,5); add(0,1,BAD,7,16'h0001,5); add(1,1,LW,7,16'h0001,5);
    add(0,1,LW,0,16'h0000,0);  add(0,1,LW,1,16'h9840,0);  add(0,1,LW,2,16'h0080,0);
    add(0,1,LW,3,16'h0180,0);  add(1,0,LW,4,16'hA000,0);  add(0,1,LW,0,16'h0000,0);
    add(0,1,LW,1,16'h9840,0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].rdy, vecs[i].ins);
      check($sformatf("vec%0d state", i), {29'd0, state}, {29'd0, vecs[i].st});
      check($sformatf("vec%0d ctl", i), {16'd0, ctl}, {16'd0, vecs[i].ctl});
      check($sformatf("vec%0d instret", i), instret, vecs[i].cnt);
      adv();
    end

    // Fetch timeout: eight not-ready cycles end in FAULT.
    drive(1, 0, ADD); adv();
    drive(0, 0, ADD); adv();
    for (int i = 0; i < TO; i++) begin
      drive(0, 0, ADD);
      check($sformatf("to_wait%0d state", i), {29'd0, state}, 32'd1);
      check($sformatf("to_wait%0d ctl", i), {16'd0, ctl}, 32'h8040);
      adv();
    end
    drive(0, 1, ADD);
    check("to_fault state", {29'd0, state}, 32'd7);
    check("to_fault flag", {31'd0, fault}, 32'd1);
    check("to_fault ctl", {16'd0, ctl}, 32'h0001);
    adv();

    // Ready on the eighth fetch cycle wins over the timeout.
    drive(1, 0, ADD); adv();
    drive(0, 0, ADD); adv();
    for (int i = 0; i < TO - 1; i++) begin drive(0, 0, ADD); adv(); end
    drive(0, 1, ADD);
    check("to_edge ctl", {16'd0, ctl}, 32'h9840);
    adv();
    drive(0, 1, ADD);
    check("to_edge state", {29'd0, state}, 32'd2);
    check("to_edge fault", {31'd0, fault}, 32'd0);
    adv();

    // Randomized run against the model.
    drive(1, 0, ADD);
    model_step(1, 0, ADD);
    adv();
    pct = 90;
    cur = ADD;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc % 256 == 0) begin
        case ($urandom_range(0, 2))
          0: pct = 5;
          1: pct = 40;
          default: pct = 90;
        endcase
      end
      r  = ($urandom_range(0, 399) == 0) || (m_st == 7 && $urandom_range(0, 5) == 0);
      rd = ($urandom_range(0, 99) < pct);
      if (m_st == 1) cur = rand_instr();
      drive(r, rd, cur);
      check("rnd state", {29'd0, state}, m_st);
      check("rnd ctl", {16'd0, ctl},
            {16'd0, exp_ctl(m_st, m_cls, rd, m_route.size() == 0)});
      check("rnd instret", instret, m_instret);
      model_step(r, rd, cur);
      adv();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
